// File: rtl/rv32_lsu_pkg.sv
// Shared encodings for the RV32 load/store unit: funct3 codes, FSM states, byte strobes.
package rv32_lsu_pkg;

  localparam int unsigned STRB_BITS = 4;

  localparam logic [2:0] F3_LB_SB = 3'b000;
  localparam logic [2:0] F3_LH_SH = 3'b001;
  localparam logic [2:0] F3_LW_SW = 3'b010;
  localparam logic [2:0] F3_LBU   = 3'b100;
  localparam logic [2:0] F3_LHU   = 3'b101;

  localparam logic [STRB_BITS-1:0] STRB_NONE    = 4'b0000;
  localparam logic [STRB_BITS-1:0] STRB_BYTE0   = 4'b0001;
  localparam logic [STRB_BITS-1:0] STRB_HALF_LO = 4'b0011;
  localparam logic [STRB_BITS-1:0] STRB_HALF_HI = 4'b1100;
  localparam logic [STRB_BITS-1:0] STRB_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Unsigned variants exist only for loads.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_LB_SB, F3_LH_SH, F3_LW_SW: f3_legal = 1'b1;
      F3_LBU, F3_LHU:               f3_legal = !is_store;
      default:                      f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_LH_SH, F3_LHU: f3_misaligned = addr_lo[0];
      F3_LW_SW:         f3_misaligned = |addr_lo;
      default:          f3_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_align.sv
// Byte-lane steering: store data/strobe replication and load extract with sign/zero extension.
module lsu_byte_align
  import rv32_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]           i_st_funct3,
  input  logic [1:0]           i_st_addr_lo,
  input  logic [XLEN-1:0]      i_store_data,
  output logic [STRB_BITS-1:0] o_wstrb_c,
  output logic [XLEN-1:0]      o_wdata_c,
  input  logic [2:0]           i_ld_funct3,
  input  logic [1:0]           i_ld_addr_lo,
  input  logic [XLEN-1:0]      i_rdata,
  output logic [XLEN-1:0]      o_load_data_c
);

  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  always_comb begin
    o_wstrb_c = STRB_NONE;
    o_wdata_c = i_store_data;
    case (i_st_funct3)
      F3_LB_SB: begin
        o_wstrb_c = STRB_BITS'(STRB_BYTE0 << i_st_addr_lo);
        o_wdata_c = XLEN'({4{i_store_data[7:0]}});
      end
      F3_LH_SH: begin
        o_wstrb_c = i_st_addr_lo[1] ? STRB_HALF_HI : STRB_HALF_LO;
        o_wdata_c = XLEN'({2{i_store_data[15:0]}});
      end
      F3_LW_SW: o_wstrb_c = STRB_WORD;
      default:  o_wstrb_c = STRB_NONE;
    endcase
  end

  always_comb begin
    w_ld_byte     = i_rdata[{i_ld_addr_lo, 3'b000} +: 8];
    w_ld_half     = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_load_data_c = '0;
    case (i_ld_funct3)
      F3_LB_SB: o_load_data_c = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
      F3_LBU:   o_load_data_c = {{(XLEN-8){1'b0}}, w_ld_byte};
      F3_LH_SH: o_load_data_c = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
      F3_LHU:   o_load_data_c = {{(XLEN-16){1'b0}}, w_ld_half};
      F3_LW_SW: o_load_data_c = i_rdata;
      default:  o_load_data_c = '0;
    endcase
  end

endmodule

// File: rtl/mem_load_store_unit.sv
// MEM-stage load/store unit: drives a ready/rvalid data-memory bus and stalls the pipeline meanwhile.
module mem_load_store_unit
  import rv32_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [2:0]           i_funct3,
  input  logic [XLEN-1:0]      i_address,
  input  logic [XLEN-1:0]      i_store_data,
  input  logic                 i_pipeline_hold,
  input  logic                 i_flush,
  output logic                 o_dmem_req,
  output logic                 o_dmem_we,
  output logic [XLEN-1:0]      o_dmem_addr,
  output logic [STRB_BITS-1:0] o_dmem_wstrb,
  output logic [XLEN-1:0]      o_dmem_wdata,
  input  logic                 i_dmem_ready,
  input  logic                 i_dmem_rvalid,
  input  logic [XLEN-1:0]      i_dmem_rdata,
  output logic [XLEN-1:0]      o_load_data,
  output logic                 o_lsu_stall,
  output logic                 o_misaligned_fault
);

  lsu_state_e           r_state, w_next_state;
  logic                 r_dmem_req, r_dmem_we, r_misaligned_fault, r_flush_lat, r_is_load;
  logic [XLEN-1:0]      r_dmem_addr, r_dmem_wdata, r_load_data;
  logic [STRB_BITS-1:0] r_dmem_wstrb;
  logic [2:0]           r_ld_funct3;
  logic [1:0]           r_ld_addr_lo;

  logic                 w_legal, w_misaligned, w_start, w_fault, w_kill, w_bus_done, w_capture;
  logic [STRB_BITS-1:0] w_st_wstrb;
  logic [XLEN-1:0]      w_st_wdata, w_ld_data;

  lsu_byte_align #(.XLEN(XLEN)) u_align (
    .i_st_funct3   (i_funct3),
    .i_st_addr_lo  (i_address[1:0]),
    .i_store_data  (i_store_data),
    .o_wstrb_c     (w_st_wstrb),
    .o_wdata_c     (w_st_wdata),
    .i_ld_funct3   (r_ld_funct3),
    .i_ld_addr_lo  (r_ld_addr_lo),
    .i_rdata       (i_dmem_rdata),
    .o_load_data_c (w_ld_data)
  );

  // Access qualification; a flush seen mid-transaction suppresses writeback but not the bus cycle.
  always_comb begin
    w_legal      = (i_mem_read ^ i_mem_write) && f3_legal(i_mem_write, i_funct3);
    w_misaligned = f3_misaligned(i_funct3, i_address[1:0]);
    w_start      = (r_state == ST_IDLE) && w_legal && !w_misaligned && !i_flush;
    w_fault      = (r_state == ST_IDLE) && w_legal && w_misaligned && !i_flush;
    w_kill       = r_flush_lat || i_flush;
    w_bus_done   = ((r_state == ST_REQ) && i_dmem_ready && (!r_is_load || i_dmem_rvalid)) ||
                   ((r_state == ST_WAIT) && i_dmem_rvalid);
    w_capture    = w_bus_done && r_is_load && !w_kill;
  end

  always_comb begin
    w_next_state = r_state;
    o_lsu_stall  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_lsu_stall = w_start;
        if (w_start) w_next_state = ST_REQ;
      end
      ST_REQ: begin
        o_lsu_stall = 1'b1;
        if (i_dmem_ready) w_next_state = !w_bus_done ? ST_WAIT : (w_kill ? ST_IDLE : ST_DONE);
      end
      ST_WAIT: begin
        o_lsu_stall = 1'b1;
        if (i_dmem_rvalid) w_next_state = w_kill ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        if (i_flush || !i_pipeline_hold) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (i_reset) o_lsu_stall = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state            <= ST_IDLE;
      r_dmem_req         <= 1'b0;
      r_dmem_we          <= 1'b0;
      r_dmem_addr        <= '0;
      r_dmem_wstrb       <= STRB_NONE;
      r_dmem_wdata       <= '0;
      r_load_data        <= '0;
      r_misaligned_fault <= 1'b0;
      r_flush_lat        <= 1'b0;
      r_is_load          <= 1'b0;
      r_ld_funct3        <= 3'b000;
      r_ld_addr_lo       <= 2'b00;
    end else begin
      r_state            <= w_next_state;
      r_misaligned_fault <= w_fault;
      r_flush_lat        <= w_kill && ((w_next_state == ST_REQ) || (w_next_state == ST_WAIT));
      if (w_start) begin
        r_dmem_req   <= 1'b1;
        r_dmem_we    <= i_mem_write;
        r_dmem_addr  <= {i_address[XLEN-1:2], 2'b00};
        r_dmem_wstrb <= i_mem_write ? w_st_wstrb : STRB_NONE;
        r_dmem_wdata <= i_mem_write ? w_st_wdata : '0;
        r_is_load    <= i_mem_read;
        r_ld_funct3  <= i_funct3;
        r_ld_addr_lo <= i_address[1:0];
      end else if ((r_state == ST_REQ) && i_dmem_ready) begin
        r_dmem_req   <= 1'b0;
        r_dmem_we    <= 1'b0;
        r_dmem_wstrb <= STRB_NONE;
      end
      if (w_capture) r_load_data <= w_ld_data;
    end
  end

  assign o_dmem_req         = r_dmem_req;
  assign o_dmem_we          = r_dmem_we;
  assign o_dmem_addr        = r_dmem_addr;
  assign o_dmem_wstrb       = r_dmem_wstrb;
  assign o_dmem_wdata       = r_dmem_wdata;
  assign o_load_data        = r_load_data;
  assign o_misaligned_fault = r_misaligned_fault;

endmodule

// File: tb/tb_mem_load_store_unit.sv
// Self-checking bench for mem_load_store_unit: vector table plus flush, hold and reset sequences.
`timescale 1ns/1ps
module tb_mem_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, pipeline_hold, flush;
  logic [2:0]  funct3;
  logic [31:0] address, store_data;
  logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data;
  logic [3:0]  dmem_wstrb;
  logic        lsu_stall, misaligned_fault;

  mem_load_store_unit #(.XLEN(32)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_mem_read(mem_read), .i_mem_write(mem_write), .i_funct3(funct3),
    .i_address(address), .i_store_data(store_data),
    .i_pipeline_hold(pipeline_hold), .i_flush(flush),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wstrb(dmem_wstrb), .o_dmem_wdata(dmem_wdata),
    .i_dmem_ready(dmem_ready), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_load_data(load_data), .o_lsu_stall(lsu_stall), .o_misaligned_fault(misaligned_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          rdy_dly;
    int          rv_dly;
    logic        has_req;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        ld_upd;
    logic [31:0] ld;
    logic        fault;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } exp_req_t;

  exp_req_t    sb_q[$];
  vec_t        vecs[16];
  vec_t        extra;
  logic [31:0] model_load;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; address = '0; store_data = '0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
  endtask

  // Drive one MEM-stage op, answer the bus per the vector's delays, and score the request and result.
  task automatic run_op(input vec_t v, input string name);
    exp_req_t    e, got;
    int          stall_cycles = 0, req_wait = 0, rv_cnt = 0, exp_stall;
    bit          accepted = 0, rv_done = 0, saw_req = 0, stable = 1, finished = 0;
    logic [31:0] exp_ld;
    got = '{default: '0};
    if (v.has_req) begin
      e.addr = {v.addr[31:2], 2'b00}; e.we = v.wr; e.strb = v.strb; e.wdata = v.wdata;
      sb_q.push_back(e);
    end
    exp_ld    = v.ld_upd ? v.ld : model_load;
    exp_stall = v.has_req ? (2 + v.rdy_dly + (v.rd ? v.rv_dly : 0)) : 0;
    for (int c = 0; c < 60 && !finished; c++) begin
      @(posedge clk); #2;
      if (c == 0) begin
        mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; address = v.addr; store_data = v.sdata;
      end
      dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = v.rdata;
      if (dmem_req) begin
        if (req_wait == v.rdy_dly) begin
          dmem_ready = 1'b1; accepted = 1;
          if (v.rd && v.rv_dly == 0) begin dmem_rvalid = 1'b1; rv_done = 1; end
        end else req_wait++;
      end else if (accepted && v.rd && !rv_done) begin
        rv_cnt++;
        if (rv_cnt == v.rv_dly) begin dmem_rvalid = 1'b1; rv_done = 1; end
      end
      @(negedge clk);
      if (lsu_stall) stall_cycles++;
      if (dmem_req) begin
        if (!saw_req) begin
          saw_req = 1;
          if (sb_q.size() == 0) check({name, "_req_without_expectation"}, 32'(sb_q.size()), 32'd1);
          else begin
            got = sb_q.pop_front();
            check({name, "_addr"}, dmem_addr, got.addr);
            check({name, "_we"}, 32'(dmem_we), 32'(got.we));
            check({name, "_strb"}, 32'(dmem_wstrb), 32'(got.strb));
            check({name, "_wdata"}, dmem_wdata, got.wdata);
          end
        end else if ({dmem_addr, dmem_we, dmem_wstrb, dmem_wdata} !== {got.addr, got.we, got.strb, got.wdata})
          stable = 0;
      end
      if (!lsu_stall) finished = 1;
    end
    check({name, "_completes"}, 32'(finished), 32'd1);
    check({name, "_stall_cycles"}, 32'(stall_cycles), 32'(exp_stall));
    check({name, "_req_seen"}, 32'(saw_req), 32'(v.has_req));
    if (v.has_req) check({name, "_req_stable"}, 32'(stable), 32'd1);
    check({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    @(posedge clk); #2; idle_inputs();
    @(negedge clk);
    check({name, "_post_req"}, 32'(dmem_req), 32'd0);
    check({name, "_fault"}, 32'(misaligned_fault), 32'(v.fault));
    check({name, "_load_data"}, load_data, exp_ld);
    @(posedge clk); #2;
    @(negedge clk);
    check({name, "_fault_pulse_end"}, 32'(misaligned_fault), 32'd0);
    model_load = exp_ld;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_req"}, 32'(dmem_req), 32'd0);
    check({name, "_we"}, 32'(dmem_we), 32'd0);
    check({name, "_addr"}, dmem_addr, 32'd0);
    check({name, "_strb"}, 32'(dmem_wstrb), 32'd0);
    check({name, "_wdata"}, dmem_wdata, 32'd0);
    check({name, "_load"}, load_data, 32'd0);
    check({name, "_stall"}, 32'(lsu_stall), 32'd0);
    check({name, "_fault"}, 32'(misaligned_fault), 32'd0);
  endtask

  initial begin
    //          rd    wr    f3      addr        sdata          rdata        rdy rv req  strb   wdata          upd   ld             fault
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h203, 32'h0,        32'h80FF1234, 0, 2, 1'b1, 4'h0, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h203, 32'h0,        32'h80FF1234, 0, 2, 1'b1, 4'h0, 32'h0,        1'b1, 32'h00000080, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h302, 32'h0000ABCD, 32'h0,        0, 0, 1'b1, 4'hC, 32'hABCDABCD, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h301, 32'h0,        32'hFFFFFFFF, 0, 0, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 1'b1, 3'b000, 32'h401, 32'h123456A5, 32'h0,        1, 0, 1'b1, 4'h2, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h502, 32'h0,        32'h80017FFF, 0, 1, 1'b1, 4'h0, 32'h0,        1'b1, 32'hFFFF8001, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'b101, 32'h500, 32'h0,        32'h8001F00D, 0, 0, 1'b1, 4'h0, 32'h0,        1'b1, 32'h0000F00D, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h600, 32'h0,        32'hCAFEF00D, 5, 1, 1'b1, 4'h0, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h702, 32'h1,        32'h0,        0, 0, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h800, 32'h0,        32'h12345678, 0, 1, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h804, 32'h55,       32'h0,        0, 0, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 1'b1, 3'b010, 32'h808, 32'h66,       32'h77,       0, 0, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,        1'b0};
    vecs[13] = '{1'b1, 1'b0, 3'b000, 32'h000, 32'h0,        32'h0000007F, 0, 1, 1'b1, 4'h0, 32'h0,        1'b1, 32'h0000007F, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 3'b001, 32'h010, 32'h12345678, 32'h0,        2, 0, 1'b1, 4'h3, 32'h56785678, 1'b0, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 1'b1, 3'b000, 32'h013, 32'h000000EE, 32'h0,        0, 0, 1'b1, 4'h8, 32'hEEEEEEEE, 1'b0, 32'h0,        1'b0};

    rst = 1'b1; pipeline_hold = 1'b0; flush = 1'b0; dmem_rdata = '0; idle_inputs();
    model_load = '0;
    #7;
    check_all_zero("reset_state");
    #5 rst = 1'b0;

    for (int i = 0; i < 16; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Flush during WAIT: bus cycle completes, no writeback, straight back to IDLE.
    @(posedge clk); #2; mem_read = 1'b1; funct3 = 3'b010; address = 32'h900; dmem_rdata = 32'h11112222;
    @(negedge clk); check("flush_idle_stall", 32'(lsu_stall), 32'd1);
    @(posedge clk); #2; dmem_ready = dmem_req;
    @(negedge clk); check("flush_req_addr", dmem_addr, 32'h900);
    @(posedge clk); #2; dmem_ready = 1'b0; flush = 1'b1; mem_read = 1'b0;
    @(negedge clk); check("flush_wait_stall", 32'(lsu_stall), 32'd1);
    @(posedge clk); #2; flush = 1'b0;
    @(negedge clk); check("flush_wait_hold_stall", 32'(lsu_stall), 32'd1);
    @(posedge clk); #2; dmem_rvalid = 1'b1;
    @(negedge clk); check("flush_rvalid_stall", 32'(lsu_stall), 32'd1);
    extra = '{1'b0, 1'b1, 3'b010, 32'h904, 32'hFEEDFACE, 32'h0, 0, 0, 1'b1, 4'hF, 32'hFEEDFACE, 1'b0, 32'h0, 1'b0};
    run_op(extra, "after_flush");

    // pipeline_hold keeps DONE (and load_data) even with a new op presented.
    pipeline_hold = 1'b1;
    extra = '{1'b1, 1'b0, 3'b010, 32'hA00, 32'h0, 32'h0BADBEEF, 0, 1, 1'b1, 4'h0, 32'h0, 1'b1, 32'h0BADBEEF, 1'b0};
    run_op(extra, "hold_load");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2; mem_write = 1'b1; funct3 = 3'b010; address = 32'hA10;
      @(negedge clk);
      check($sformatf("hold%0d_load", i), load_data, 32'h0BADBEEF);
      check($sformatf("hold%0d_stall", i), 32'(lsu_stall), 32'd0);
      check($sformatf("hold%0d_req", i), 32'(dmem_req), 32'd0);
    end
    @(posedge clk); #2; pipeline_hold = 1'b0; idle_inputs();
    @(negedge clk);

    // Reset in WAIT, then a stale rvalid after release.
    @(posedge clk); #2; mem_read = 1'b1; funct3 = 3'b010; address = 32'hC00; dmem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    @(posedge clk); #2; dmem_ready = dmem_req;
    @(negedge clk); check("rst_seq_req", 32'(dmem_req), 32'd1);
    @(posedge clk); #2; dmem_ready = 1'b0;
    #1 rst = 1'b1;
    #1 check_all_zero("async_reset");
    #1 mem_read = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #2; dmem_rvalid = 1'b1;
    @(negedge clk);
    check("late_rvalid_load", load_data, 32'd0);
    check("late_rvalid_stall", 32'(lsu_stall), 32'd0);
    check("late_rvalid_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #2; dmem_rvalid = 1'b0;
    @(negedge clk); check("late_rvalid_load_after", load_data, 32'd0);
    model_load = '0;
    run_op(vecs[13], "post_reset_lb");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
